// File: rtl/branch_resolver.sv
// In-order tracker of outstanding branch predictions. It pairs each resolution with the
// oldest prediction and emits training/mispredict pulses and statistics. Define BRES_FLUSH_EN to flush younger entries on a mispredict.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pred_valid,
  input  logic                    pred_taken,
  input  logic                    res_valid,
  input  logic                    res_taken,
  output logic                    upd_result,
  output logic                    upd_taken,
  output logic                    mispredict,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic [CNT_W-1:0]        branch_cnt,
  output logic [CNT_W-1:0]        mispred_cnt,
  output logic                    err_ovf,
  output logic                    err_udf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  logic [DEPTH-1:0] entries;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [PTR_W:0]   count_nxt;
  logic             pop;
  logic             push;
  logic             drop;
  logic             underflow;
  logic             miss;
  logic             flush;

  always_comb begin
    pop        = res_valid & ~empty;
    underflow  = res_valid & empty;
    miss       = pop & (entries[rd_ptr] ^ res_taken);
`ifdef BRES_FLUSH_EN
    flush      = miss;
`else
    flush      = 1'b0;
`endif
    // A push that coincides with a flush is silently discarded, not counted as overflow.
    push       = pred_valid & (~full | pop) & ~flush;
    drop       = pred_valid & full & ~pop;
    rd_ptr_inc = rd_ptr + PTR_ONE;
    count_nxt  = count;
    if (flush)
      count_nxt = '0;
    else if (push & ~pop)
      count_nxt = count + CNT_ONE;
    else if (pop & ~push)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst_n && push)
      entries[wr_ptr] <= pred_taken;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      upd_result  <= 1'b0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
      err_ovf     <= 1'b0;
      err_udf     <= 1'b0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr_inc;
      if (flush)
        wr_ptr <= rd_ptr_inc;
      else if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      count      <= count_nxt;
      full       <= (count_nxt == FULL_CNT);
      empty      <= (count_nxt == '0);
      upd_result <= pop;
      upd_taken  <= pop & res_taken;
      mispredict <= miss;
      if (pop && branch_cnt != '1)
        branch_cnt <= branch_cnt + STAT_ONE;
      if (miss && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + STAT_ONE;
      if (drop)
        err_ovf <= 1'b1;
      if (underflow)
        err_udf <= 1'b1;
    end
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of outstanding-prediction entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the statistics counters.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, using these ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
REQ-004 The block SHALL have these ports:
- pred_valid  input  1  a prediction was issued this cycle (push).
- pred_taken  input  1  the predicted direction.
- res_valid  input  1  the oldest branch resolved this cycle (pop).
- res_taken  input  1  the actual direction.
- upd_result  output  1  one-cycle training pulse to the predictor.
- upd_taken  output  1  the direction that goes with upd_result.
- mispredict  output  1  one-cycle pulse; the resolved branch was mispredicted.
- full  output  1  occupancy equals DEPTH.
- empty  output  1  occupancy equals zero.
- count  output  $clog2(DEPTH)+1  current occupancy.
- branch_cnt  output  CNT_W  number of resolved branches.
- mispred_cnt  output  CNT_W  number of mispredicted branches.
- err_ovf  output  1  sticky flag: a push was dropped.
- err_udf  output  1  sticky flag: a pop was attempted while empty.

Function
REQ-005 The block SHALL hold predictions in an in-order circular buffer of DEPTH 1-bit entries, with a read pointer, a write pointer and an occupancy counter.
REQ-006 A push SHALL occur at a rising edge when pred_valid=1 and the buffer is not full, or when pred_valid=1, the buffer is full and a pop occurs in the same cycle; pred_taken is written at the write pointer and the write pointer advances modulo DEPTH.
REQ-007 A push under any other full condition SHALL be dropped, SHALL set err_ovf, and SHALL leave the buffer state unchanged.
REQ-008 A pop SHALL occur at a rising edge when res_valid=1 and the buffer is not empty; the read pointer advances modulo DEPTH.
REQ-009 res_valid=1 while the buffer is empty SHALL set err_udf and SHALL produce no update pulse and no counter change, even if a push occurs in the same cycle; there is no bypass from push to pop.
REQ-010 A simultaneous push and pop SHALL leave count unchanged.
REQ-011 Each pop SHALL produce, one cycle later, registered pulses lasting exactly one cycle:
- upd_result=1;
- upd_taken equal to res_taken;
- mispredict equal to (stored entry XOR res_taken).
REQ-012 upd_taken SHALL be 0 whenever upd_result=0.
REQ-013 Each pop SHALL increment branch_cnt, and SHALL also increment mispred_cnt when the pop mispredicts; both counters update in the same edge as the pop and saturate at 2^CNT_W-1.
REQ-014 full, empty and count SHALL be registered outputs that reflect the state after the most recent edge.
REQ-015 err_ovf and err_udf SHALL remain set until reset.

Reset
REQ-016 With rst_n=0 at a rising edge, the block SHALL clear both pointers, count, branch_cnt, mispred_cnt, upd_result, upd_taken, mispredict, err_ovf, err_udf and full, and SHALL set empty=1.
REQ-017 Reset SHALL take priority over any simultaneous push or pop, and entry contents need not be cleared.
REQ-018 Reset asserted while pulses are in flight SHALL suppress those pulses.

Configuration
REQ-019 When macro BRES_FLUSH_EN is defined, a mispredicting pop SHALL discard all younger entries at the same edge (count becomes 0, write pointer is set to the new read pointer), and a push in that same cycle SHALL also be discarded without setting err_ovf.
REQ-020 When BRES_FLUSH_EN is not defined, a mispredicting pop SHALL remove only the oldest entry, and all other behaviour is unchanged.

Verification
REQ-021 After reset, push 1,0,1 on three cycles, then pop with res_taken=1,1,1 -> upd_result pulses 3 times; mispredict only on the second pop; branch_cnt=3; mispred_cnt=1.
REQ-022 DEPTH=4: push 5 times without pops -> full=1 and count=4 after the 4th push; the 5th push sets err_ovf=1; count stays 4.
REQ-023 Full buffer, simultaneous push and pop for 8 cycles -> count stays 4; pointers wrap twice; FIFO order is preserved.
REQ-024 Empty buffer, res_valid=1 with pred_valid=1 -> err_udf=1; no upd_result; count=1 next cycle.
REQ-025 BRES_FLUSH_EN defined: push 0,1,1, then pop with res_taken=1 -> mispredict=1 and count=0; without the macro -> count=2.
REQ-026 CNT_W=2: 5 mispredicting pops -> mispred_cnt saturates at 3 and branch_cnt saturates at 3.
